// File: rtl/lrf_pkg.sv
// Shared LRF definitions: frame geometry, word layout and TX FSM states.
package lrf_pkg;

    localparam int WORD_WIDTH      = 128;
    localparam int PIXEL_WIDTH     = 8;
    localparam int PIXELS_PER_WORD = WORD_WIDTH / PIXEL_WIDTH;
    localparam int IMAGE_DIM       = 512;
    localparam int WORDS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_WORD;
    localparam int WIDX_W          = $clog2(WORDS_PER_FRAME);

    typedef enum logic {
        TX_DROP = 1'b0,
        TX_PASS = 1'b1
    } tx_state_e;

    // Counter width that stays at least one bit when n is zero.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/lrf_axis_frame_tx_if.sv
// AXI4-Stream beat bundle between the frame transmitter and its sink.
interface lrf_axis_frame_tx_if #(
    parameter int W = 128
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lrf_sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop and zeroed head while empty.
module lrf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == CW'(DEPTH));
        do_pop  = pop_i & ~empty_o;
        // A pop frees the slot a same-cycle push lands in.
        do_push = push_i & (~full_o | do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        data_o  = empty_o ? '0 : mem_q[rd_q];
        count_o = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lrf_axis_frame_tx.sv
// M_AXIS frame transmitter: drops warm-up words, buffers, tags tlast per frame.
module lrf_axis_frame_tx
    import lrf_pkg::*;
#(
    parameter int DROP_WORDS = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    lrf_axis_frame_tx_if.master   m_axis,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  overflow
);
    localparam int DCW = cnt_w(DROP_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam tx_state_e         RST_ST    = (DROP_WORDS == 0) ? TX_PASS : TX_DROP;
    localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(WORDS_PER_FRAME - 1);
    localparam logic [DCW-1:0]    DROP_LAST = DCW'((DROP_WORDS > 0) ? DROP_WORDS - 1 : 0);
    localparam logic [CW-1:0]     RDY_MAX   = CW'(FIFO_DEPTH - 2);

    tx_state_e         state_q, state_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [DCW-1:0]    drop_cnt_q, drop_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              ovf_q, ovf_d;

    logic                  push, pop, full, empty, is_last;
    logic                  head_last;
    logic [WORD_WIDTH-1:0] head_data;
    logic [CW-1:0]         count, count_nx;

    lrf_sync_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (s_axis_aclk),
        .rst_i   (s_axis_areset),
        .push_i  (push),
        .data_i  ({is_last, in_data}),
        .pop_i   (pop),
        .data_o  ({head_last, head_data}),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q;
        push        = 1'b0;
        is_last     = (word_idx_q == LAST_IDX);
        pop         = ~empty & m_axis.tready;
        done_d      = pop & head_last;
        frame_cnt_d = frame_cnt_q + 16'(done_d);

        unique case (state_q)
            TX_DROP: begin
                if (in_valid) begin
                    if (drop_cnt_q == DROP_LAST) begin
                        drop_cnt_d = '0;
                        state_d    = TX_PASS;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            TX_PASS: begin
                if (in_valid) begin
                    if (~full | pop) begin
                        push = 1'b1;
                        if (is_last) begin
                            word_idx_d = '0;
                            state_d    = RST_ST;
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = RST_ST;
        endcase

        // Keep one slot spare for the word emitted as in_ready falls.
        count_nx   = count + CW'(push) - CW'(pop);
        in_ready_d = (count_nx <= RDY_MAX);
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q     <= RST_ST;
            word_idx_q  <= '0;
            drop_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            drop_cnt_q  <= drop_cnt_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign frame_done    = done_q;
    assign frame_cnt     = frame_cnt_q;
    assign overflow      = ovf_q;
    assign m_axis.tvalid = ~empty;
    assign m_axis.tdata  = head_data;
    assign m_axis.tlast  = head_last;

endmodule

// File: tb/tb_lrf_axis_frame_tx.sv
// Directed bench for lrf_axis_frame_tx (DROP_WORDS=2 and DROP_WORDS=0 builds).
module tb_lrf_axis_frame_tx;
    import lrf_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_valid0 = 1'b0;
    logic [WORD_WIDTH-1:0] in_data = '0;
    logic                  in_ready, in_ready0;
    logic                  frame_done, frame_done0;
    logic [15:0]           frame_cnt, frame_cnt0;
    logic                  overflow, overflow0;

    int n_chk = 0;
    int n_fail = 0;

    logic [WORD_WIDTH:0] cap[$];
    int                  dones[$];
    logic [15:0]         fcnts[$];

    lrf_axis_frame_tx_if #(.W(WORD_WIDTH)) ax ();
    lrf_axis_frame_tx_if #(.W(WORD_WIDTH)) ax0 ();

    lrf_axis_frame_tx #(.DROP_WORDS(2), .FIFO_DEPTH(4)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .m_axis        (ax.master),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .overflow      (overflow)
    );

    lrf_axis_frame_tx #(.DROP_WORDS(0), .FIFO_DEPTH(4)) dut0 (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .in_valid      (in_valid0),
        .in_data       (in_data),
        .in_ready      (in_ready0),
        .m_axis        (ax0.master),
        .frame_done    (frame_done0),
        .frame_cnt     (frame_cnt0),
        .overflow      (overflow0)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_WIDTH-1:0] wd(input int k);
        return {4{32'(k)}};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Drives n consecutive words with tready=1 and records every beat.
    task automatic run_stream(input bit sel, input int base, input int n, input int drain);
        cap.delete();
        dones.delete();
        fcnts.delete();
        ax.tready = 1'b1;
        ax0.tready = 1'b1;
        for (int i = 0; i < n + drain; i++) begin
            if (!sel) begin
                if (frame_done) begin
                    dones.push_back(cap.size());
                    fcnts.push_back(frame_cnt);
                end
                if (ax.tvalid) cap.push_back({ax.tlast, ax.tdata});
                in_valid = (i < n);
            end else begin
                if (frame_done0) begin
                    dones.push_back(cap.size());
                    fcnts.push_back(frame_cnt0);
                end
                if (ax0.tvalid) cap.push_back({ax0.tlast, ax0.tdata});
                in_valid0 = (i < n);
            end
            in_data = wd(base + i);
            cyc();
        end
        in_valid = 1'b0;
        in_valid0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ax.tready = 1'b0;
        ax0.tready = 1'b1;
        cyc();
        cyc();
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_chk++; if (ax.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b expected 0", ax.tvalid); end
        n_chk++; if (ax.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b expected 0", ax.tlast); end
        n_chk++; if (ax.tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h expected 0", ax.tdata); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", frame_done); end
        n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_fcnt: got %0d expected 0", frame_cnt); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        rst = 1'b0;
        cyc();
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
        n_chk++; if (ax.tvalid !== 1'b0) begin n_fail++; $display("FAIL rel_tvalid: got %b expected 0", ax.tvalid); end
    endtask

    task automatic test_stream();
        logic [WORD_WIDTH:0] e;
        int fr, ix;
        run_stream(1'b0, 0, WORDS_PER_FRAME + 14, 4);
        n_chk++; if (cap.size() !== WORDS_PER_FRAME + 10) begin n_fail++; $display("FAIL stream_beats: got %0d expected %0d", cap.size(), WORDS_PER_FRAME + 10); end
        for (int j = 0; j < cap.size(); j++) begin
            fr = j / WORDS_PER_FRAME;
            ix = j % WORDS_PER_FRAME;
            e = {(ix == WORDS_PER_FRAME - 1), wd(fr * (WORDS_PER_FRAME + 2) + 2 + ix)};
            n_chk++;
            if (cap[j] !== e) begin n_fail++; $display("FAIL stream_beat[%0d]: got %h expected %h", j, cap[j], e); break; end
        end
        n_chk++; if (dones.size() !== 1) begin n_fail++; $display("FAIL stream_done_cnt: got %0d expected 1", dones.size()); end
        if (dones.size() > 0) begin
            n_chk++; if (dones[0] !== WORDS_PER_FRAME) begin n_fail++; $display("FAIL stream_done_pos: got %0d expected %0d", dones[0], WORDS_PER_FRAME); end
            n_chk++; if (fcnts[0] !== 16'd1) begin n_fail++; $display("FAIL stream_fcnt: got %0d expected 1", fcnts[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic                  stall;
        logic [WORD_WIDTH-1:0] hd;
        logic                  hl;
        int                    nb, sent;
        do_reset();
        stall = 1'b0;
        hd = '0;
        hl = 1'b0;
        nb = 0;
        sent = 0;
        for (int i = 0; i < 420; i++) begin
            ax.tready = (i < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                n_chk++;
                if (ax.tvalid !== 1'b1 || ax.tdata !== hd || ax.tlast !== hl) begin
                    n_fail++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=%h", ax.tvalid, ax.tdata, hd);
                end
            end
            if (ax.tvalid && ax.tready) begin
                n_chk++;
                if (ax.tdata !== wd(2 + nb) || ax.tlast !== 1'b0) begin
                    n_fail++; $display("FAIL bp_beat[%0d]: got %h expected %h", nb, ax.tdata, wd(2 + nb));
                end
                nb++;
            end
            stall = ax.tvalid && !ax.tready;
            hd = ax.tdata;
            hl = ax.tlast;
            in_valid = (i < 400) ? in_ready : 1'b0;
            in_data = wd(sent);
            if (in_valid) sent++;
            cyc();
        end
        n_chk++; if (nb !== sent - 2) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", nb, sent - 2); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        ax.tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = wd(100 + i);
            cyc();
            if (i == 3) begin
                n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy_c2: got %b expected 1", in_ready); end
            end
            if (i == 4) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy_c3: got %b expected 0", in_ready); end
            end
        end
        n_chk++; if (ax.tvalid !== 1'b1 || ax.tdata !== wd(102)) begin n_fail++; $display("FAIL full_head: got %h expected %h", ax.tdata, wd(102)); end
        in_data = wd(106);
        ax.tready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf: got %b expected 0", overflow); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pp_rdy: got %b expected 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (ax.tvalid !== 1'b1 || ax.tdata !== wd(103 + i)) begin
                n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, ax.tdata, wd(103 + i));
            end
            cyc();
            if (i == 0) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_rdy_c3: got %b expected 0", in_ready); end
            end
            if (i == 1) begin
                n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_rdy_c2: got %b expected 1", in_ready); end
            end
        end
        n_chk++; if (ax.tvalid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", ax.tvalid); end
    endtask

    task automatic test_overflow();
        logic [WORD_WIDTH:0] e;
        do_reset();
        ax.tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data = wd(200 + i);
            cyc();
            if (i == 5) begin
                n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        in_valid = 1'b0;
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        // Remaining words of the frame; the dropped 5th word must not count.
        run_stream(1'b0, 300, WORDS_PER_FRAME - 4, 6);
        n_chk++; if (cap.size() !== WORDS_PER_FRAME) begin n_fail++; $display("FAIL ovf_beats: got %0d expected %0d", cap.size(), WORDS_PER_FRAME); end
        for (int j = 0; j < cap.size(); j++) begin
            e = {(j == WORDS_PER_FRAME - 1), (j < 4) ? wd(202 + j) : wd(300 + j - 4)};
            n_chk++;
            if (cap[j] !== e) begin n_fail++; $display("FAIL ovf_beat[%0d]: got %h expected %h", j, cap[j], e); break; end
        end
        n_chk++; if (dones.size() !== 1) begin n_fail++; $display("FAIL ovf_done_cnt: got %0d expected 1", dones.size()); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [WORD_WIDTH:0] e;
        run_stream(1'b0, 1000, 103, 0);
        n_chk++; if (cap.size() !== 100) begin n_fail++; $display("FAIL mid_beats: got %0d expected 100", cap.size()); end
        n_chk++; if (ax.tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b expected 1", ax.tvalid); end
        n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_fcnt_pre: got %0d expected 1", frame_cnt); end
        rst = 1'b1;
        cyc();
        n_chk++; if (ax.tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b expected 0", ax.tvalid); end
        n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_fcnt: got %0d expected 0", frame_cnt); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
        rst = 1'b0;
        run_stream(1'b0, 5000, WORDS_PER_FRAME + 2, 4);
        n_chk++; if (cap.size() !== WORDS_PER_FRAME) begin n_fail++; $display("FAIL mid_re_beats: got %0d expected %0d", cap.size(), WORDS_PER_FRAME); end
        for (int j = 0; j < cap.size(); j++) begin
            e = {(j == WORDS_PER_FRAME - 1), wd(5002 + j)};
            n_chk++;
            if (cap[j] !== e) begin n_fail++; $display("FAIL mid_beat[%0d]: got %h expected %h", j, cap[j], e); break; end
        end
        n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_fcnt_post: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_drop0();
        logic [WORD_WIDTH:0] e;
        run_stream(1'b1, 0, WORDS_PER_FRAME + 5, 4);
        n_chk++; if (cap.size() !== WORDS_PER_FRAME + 5) begin n_fail++; $display("FAIL d0_beats: got %0d expected %0d", cap.size(), WORDS_PER_FRAME + 5); end
        for (int j = 0; j < cap.size(); j++) begin
            e = {(j == WORDS_PER_FRAME - 1), wd(j)};
            n_chk++;
            if (cap[j] !== e) begin n_fail++; $display("FAIL d0_beat[%0d]: got %h expected %h", j, cap[j], e); break; end
        end
        n_chk++; if (dones.size() !== 1) begin n_fail++; $display("FAIL d0_done_cnt: got %0d expected 1", dones.size()); end
        if (dones.size() > 0) begin
            n_chk++; if (fcnts[0] !== 16'd1) begin n_fail++; $display("FAIL d0_fcnt: got %0d expected 1", fcnts[0]); end
        end
        n_chk++; if (overflow0 !== 1'b0 || in_ready0 !== 1'b1) begin n_fail++; $display("FAIL d0_status: got ovf=%b rdy=%b expected ovf=0 rdy=1", overflow0, in_ready0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pushpop();
        test_overflow();
        test_reset_mid();
        test_drop0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
